// File: rtl/battleship_pkg.sv
// Shared constants, fleet table, FSM state type and lookup helper
// for the battleship fleet placement logic.
package battleship_pkg;

  localparam int MAP_W         = 35;
  // COLS counts y positions (0..4) and ROWS counts x positions (0..6).
  localparam int COLS          = 5;
  localparam int ROWS          = 7;
  localparam int NUM_SHIPS     = 3;
  localparam int REJECT_CYCLES = 8;
  localparam int CNT_W         = 3;

  localparam logic [1:0] SHIP_LEN [NUM_SHIPS] = '{2'd3, 2'd2, 2'd1};

  typedef enum logic [1:0] {
    PLACE  = 2'd0,
    REJECT = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Length of the ship at a given fleet index; 0 once the fleet is complete.
  function automatic logic [1:0] ship_len(input logic [1:0] idx);
    case (idx)
      2'd0:    return SHIP_LEN[0];
      2'd1:    return SHIP_LEN[1];
      2'd2:    return SHIP_LEN[2];
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fleet_map_writer_if.sv
// Cursor/button inputs and map/status outputs of the fleet map writer.
interface fleet_map_writer_if;

  logic [2:0]                       x_coord_code;
  logic [2:0]                       y_coord_code;
  logic                             orient;
  logic                             place_n;
  logic                             clear;
  logic [battleship_pkg::MAP_W-1:0] map;
  logic [battleship_pkg::MAP_W-1:0] preview;
  logic [1:0]                       ship_idx;
  logic                             error;
  logic                             done;

  modport master (
    output x_coord_code, y_coord_code, orient, place_n, clear,
    input  map, preview, ship_idx, error, done
  );

  modport slave (
    input  x_coord_code, y_coord_code, orient, place_n, clear,
    output map, preview, ship_idx, error, done
  );

endinterface

// File: rtl/ship_mask_gen.sv
// Combinational ship footprint: cells covered from an anchor along +x or +y,
// plus a flag saying whether every covered cell is on the board.
module ship_mask_gen
  import battleship_pkg::*;
(
  input  logic [2:0]       x,
  input  logic [2:0]       y,
  input  logic             orient,
  input  logic [1:0]       length,
  output logic [MAP_W-1:0] mask,
  output logic             in_bounds
);

  logic [MAP_W-1:0] cell_mask [3];
  logic [2:0]       cell_ok;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cell
      logic [3:0] cx;
      logic [3:0] cy;
      logic [5:0] bit_idx;
      logic       used;
      logic       on_board;

      assign used     = (2'(gi) < length);
      assign cx       = {1'b0, x} + (orient ? 4'd0 : 4'(gi));
      assign cy       = {1'b0, y} + (orient ? 4'(gi) : 4'd0);
      assign on_board = (cx < 4'(ROWS)) && (cy < 4'(COLS));
      // Only meaningful when on_board; row 0 sits in the top bits.
      assign bit_idx  = 6'(4'(COLS - 1) - cy) * 6'(ROWS) + 6'(cx);

      assign cell_ok[gi]   = !used || on_board;
      assign cell_mask[gi] = (used && on_board) ? (MAP_W'(1) << bit_idx) : '0;
    end
  endgenerate

  assign mask      = cell_mask[0] | cell_mask[1] | cell_mask[2];
  assign in_bounds = &cell_ok;

endmodule

// File: rtl/fleet_map_writer.sv
// Places a fixed three-ship fleet onto a 7x5 map one button press at a time,
// rejecting off-board or overlapping placements with a timed error flag.
module fleet_map_writer
  import battleship_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  fleet_map_writer_if.slave bus
);

  state_t           state_reg, state_next;
  logic [MAP_W-1:0] map_reg, map_next;
  logic [1:0]       idx_reg, idx_next;
  logic             error_reg, error_next;
  logic             done_reg, done_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic             sync1_reg, sync2_reg, prev_reg;
  logic [1:0]       live_reg;
  logic             armed_reg;
  logic             press;

  logic [MAP_W-1:0] mask;
  logic             in_bounds;

  // live_reg marks when sync2 holds a real sample rather than its reset value;
  // the detector only arms after a genuine released level, so a button held
  // through reset cannot produce a commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
      live_reg  <= 2'b00;
      armed_reg <= 1'b0;
    end else begin
      sync1_reg <= bus.place_n;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      live_reg  <= {live_reg[0], 1'b1};
      armed_reg <= armed_reg | (live_reg[1] & sync2_reg);
    end
  end

  assign press = armed_reg & prev_reg & ~sync2_reg;

  ship_mask_gen u_mask (
    .x         (bus.x_coord_code),
    .y         (bus.y_coord_code),
    .orient    (bus.orient),
    .length    (ship_len(idx_reg)),
    .mask      (mask),
    .in_bounds (in_bounds)
  );

  always_comb begin
    state_next = state_reg;
    map_next   = map_reg;
    idx_next   = idx_reg;
    error_next = error_reg;
    cnt_next   = cnt_reg;
    if (bus.clear) begin
      state_next = PLACE;
      map_next   = '0;
      idx_next   = 2'd0;
      error_next = 1'b0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        PLACE: begin
          if (press) begin
            if (in_bounds && ((mask & map_reg) == '0)) begin
              map_next = map_reg | mask;
              idx_next = idx_reg + 2'd1;
              if (idx_reg == 2'd2) state_next = DONE;
            end else begin
              state_next = REJECT;
              error_next = 1'b1;
              cnt_next   = CNT_W'(REJECT_CYCLES - 1);
            end
          end
        end
        REJECT: begin
          if (cnt_reg == '0) begin
            state_next = PLACE;
            error_next = 1'b0;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        DONE:    state_next = DONE;
        default: state_next = PLACE;
      endcase
    end
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= PLACE;
      map_reg   <= '0;
      idx_reg   <= 2'd0;
      error_reg <= 1'b0;
      done_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      map_reg   <= map_next;
      idx_reg   <= idx_next;
      error_reg <= error_next;
      done_reg  <= done_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign bus.map      = map_reg;
  assign bus.ship_idx = idx_reg;
  assign bus.error    = error_reg;
  assign bus.done     = done_reg;
  assign bus.preview  = (state_reg == PLACE && in_bounds) ? (map_reg | mask) : map_reg;

endmodule

// File: tb/tb_fleet_map_writer.sv
// Directed bench for fleet_map_writer: placements, rejects, clear, reset
// with the button held, checked against hand-computed map values.
module tb_fleet_map_writer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fleet_map_writer_if bus ();

  fleet_map_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_xy(input logic [2:0] x, input logic [2:0] y, input logic o);
    bus.x_coord_code = x;
    bus.y_coord_code = y;
    bus.orient       = o;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset       = 1'b0;
    bus.place_n = 1'b1;
    bus.clear   = 1'b0;
    set_xy(3'd0, 3'd0, 1'b0);
    tick(2);
    chk("rst_map", 64'(bus.map), 64'h0);
    chk("rst_idx", 64'(bus.ship_idx), 64'd0);
    chk("rst_error", 64'(bus.error), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_preview", 64'(bus.preview), 64'h070000000);
    reset = 1'b1;
    tick(4);

    // Ship 0 at (0,0) along +x
    bus.place_n = 1'b0;
    tick(2);
    chk("s0_early_map", 64'(bus.map), 64'h0);
    tick(1);
    chk("s0_map", 64'(bus.map), 64'h070000000);
    chk("s0_idx", 64'(bus.ship_idx), 64'd1);
    bus.place_n = 1'b1;
    tick(3);

    // Ship 1 at (6,4) along +y runs off the board
    set_xy(3'd6, 3'd4, 1'b1);
    #1;
    chk("s1_oob_preview", 64'(bus.preview), 64'h070000000);
    bus.place_n = 1'b0;
    tick(3);
    chk("s1_rej_error", 64'(bus.error), 64'd1);
    chk("s1_rej_map", 64'(bus.map), 64'h070000000);
    chk("s1_rej_idx", 64'(bus.ship_idx), 64'd1);
    bus.place_n = 1'b1;
    set_xy(3'd6, 3'd3, 1'b1);
    tick(7);
    chk("s1_rej_error_last", 64'(bus.error), 64'd1);
    chk("s1_rej_preview", 64'(bus.preview), 64'h070000000);
    tick(1);
    chk("s1_rej_error_drop", 64'(bus.error), 64'd0);
    chk("s1_place_preview", 64'(bus.preview), 64'h070002040);

    bus.place_n = 1'b0;
    tick(3);
    chk("s1_map", 64'(bus.map), 64'h070002040);
    chk("s1_idx", 64'(bus.ship_idx), 64'd2);
    bus.place_n = 1'b1;
    tick(3);

    // Anchor out of range gives no mask in preview
    set_xy(3'd7, 3'd0, 1'b0);
    #1;
    chk("x7_preview", 64'(bus.preview), 64'h070002040);
    set_xy(3'd0, 3'd5, 1'b0);
    #1;
    chk("y5_preview", 64'(bus.preview), 64'h070002040);

    // Ship 2 overlapping ship 0, with a second press during the reject
    set_xy(3'd1, 3'd0, 1'b0);
    bus.place_n = 1'b0;
    tick(3);
    chk("s2_rej_error", 64'(bus.error), 64'd1);
    chk("s2_rej_map", 64'(bus.map), 64'h070002040);
    bus.place_n = 1'b1;
    tick(2);
    set_xy(3'd3, 3'd2, 1'b0);
    bus.place_n = 1'b0;
    tick(3);
    chk("s2_ign_error", 64'(bus.error), 64'd1);
    chk("s2_ign_map", 64'(bus.map), 64'h070002040);
    bus.place_n = 1'b1;
    tick(2);
    chk("s2_ign_error_last", 64'(bus.error), 64'd1);
    tick(1);
    chk("s2_ign_error_drop", 64'(bus.error), 64'd0);
    tick(3);
    chk("s2_not_queued_map", 64'(bus.map), 64'h070002040);
    chk("s2_not_queued_idx", 64'(bus.ship_idx), 64'd2);

    // Ship 2 at (3,2) completes the fleet
    bus.place_n = 1'b0;
    tick(3);
    chk("s2_map", 64'(bus.map), 64'h070022040);
    chk("s2_idx", 64'(bus.ship_idx), 64'd3);
    chk("s2_done", 64'(bus.done), 64'd1);
    bus.place_n = 1'b1;
    tick(3);

    set_xy(3'd4, 3'd4, 1'b0);
    #1;
    chk("done_preview", 64'(bus.preview), 64'h070022040);
    bus.place_n = 1'b0;
    tick(3);
    chk("done_press_map", 64'(bus.map), 64'h070022040);
    chk("done_press_idx", 64'(bus.ship_idx), 64'd3);
    chk("done_press_error", 64'(bus.error), 64'd0);
    chk("done_press_done", 64'(bus.done), 64'd1);
    bus.place_n = 1'b1;
    tick(3);

    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    chk("clr_done_map", 64'(bus.map), 64'h0);
    chk("clr_done_idx", 64'(bus.ship_idx), 64'd0);
    chk("clr_done_done", 64'(bus.done), 64'd0);

    // clear on the same edge as a valid commit
    set_xy(3'd0, 3'd0, 1'b0);
    bus.place_n = 1'b0;
    tick(2);
    bus.clear = 1'b1;
    tick(1);
    chk("clr_press_map", 64'(bus.map), 64'h0);
    chk("clr_press_idx", 64'(bus.ship_idx), 64'd0);
    chk("clr_press_error", 64'(bus.error), 64'd0);
    bus.clear   = 1'b0;
    bus.place_n = 1'b1;
    tick(3);
    chk("clr_press_after_map", 64'(bus.map), 64'h0);

    // clear during REJECT
    set_xy(3'd5, 3'd0, 1'b0);
    bus.place_n = 1'b0;
    tick(3);
    chk("clr_rej_error_set", 64'(bus.error), 64'd1);
    bus.place_n = 1'b1;
    tick(2);
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    chk("clr_rej_error", 64'(bus.error), 64'd0);
    chk("clr_rej_map", 64'(bus.map), 64'h0);
    chk("clr_rej_idx", 64'(bus.ship_idx), 64'd0);
    tick(8);
    chk("clr_rej_error_stays", 64'(bus.error), 64'd0);

    set_xy(3'd0, 3'd1, 1'b0);
    bus.place_n = 1'b0;
    tick(3);
    chk("post_clr_map", 64'(bus.map), 64'h000E00000);
    chk("post_clr_idx", 64'(bus.ship_idx), 64'd1);
    bus.place_n = 1'b1;
    tick(3);

    // Reset with the button held low
    bus.place_n = 1'b0;
    tick(1);
    reset = 1'b0;
    #1;
    chk("hold_rst_map", 64'(bus.map), 64'h0);
    chk("hold_rst_idx", 64'(bus.ship_idx), 64'd0);
    tick(3);
    reset = 1'b1;
    tick(6);
    chk("hold_rel_map", 64'(bus.map), 64'h0);
    chk("hold_rel_idx", 64'(bus.ship_idx), 64'd0);
    bus.place_n = 1'b1;
    tick(3);
    bus.place_n = 1'b0;
    tick(3);
    chk("hold_new_press_map", 64'(bus.map), 64'h000E00000);
    chk("hold_new_press_idx", 64'(bus.ship_idx), 64'd1);
    bus.place_n = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fleet_map_writer.md
FLEET_MAP_WRITER -- requirements
Module: fleet_map_writer

Interface
REQ-001 The block SHALL have exactly one clock, clk, with an asynchronous active-low reset named reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 Ports (name, direction, width, meaning; clock and reset first):
- clk  input  1  system clock (post-divider game clock)
- reset  input  1  asynchronous active-low reset
- x_coord_code  input  3  cursor x; valid 0..6
- y_coord_code  input  3  cursor y; valid 0..4
- orient  input  1  0 = ship extends toward +x, 1 = ship extends toward +y
- place_n  input  1  active-low placement button, asynchronous to clk, already debounced
- clear  input  1  synchronous active-high: discard fleet and restart
- map  output  35  committed fleet map; bit index = (4 - y)*7 + x
- preview  output  35  map OR current ship mask (mask only when in bounds); feeds the display mux
- ship_idx  output  2  index of the ship being placed (0..2); 3 when done
- error  output  1  high while a rejected placement is signalled
- done  output  1  high when the full fleet is committed

Function
REQ-003 The fleet SHALL be fixed: ship 0 has length 3, ship 1 has length 2, ship 2 has length 1.
REQ-004 place_n SHALL pass through a two-flop synchronizer followed by a falling-edge detector. One press SHALL produce exactly one commit attempt, at rising edge N+2, where N is the first edge that samples place_n low.
REQ-005 FSM states SHALL be PLACE, REJECT and DONE; the reset state SHALL be PLACE.
REQ-006 In PLACE, a press SHALL be valid only when all cells of the current ship lie within x 0..6 and y 0..4 and none of them is already set in map.
REQ-007 A valid press SHALL OR the ship mask into map and increment ship_idx at the same clock edge. If ship_idx was 2, the FSM SHALL enter DONE at that edge.
REQ-008 An invalid press SHALL leave map and ship_idx unchanged and enter REJECT.
- error SHALL go high at the same edge and stay high for exactly REJECT_CYCLES = 8 cycles.
- The FSM SHALL then return to PLACE.
REQ-009 Presses detected in REJECT or DONE SHALL be ignored and SHALL NOT be queued.
REQ-010 Output levels:
- done SHALL be high exactly when the state is DONE.
- ship_idx SHALL read 3 in DONE.
- preview SHALL equal map in DONE and in REJECT.
REQ-011 clear SHALL have priority over a press in the same cycle, in every state. On the next edge it SHALL set map = 0, ship_idx = 0, error = 0, state = PLACE and clear the reject counter.
REQ-012 Out-of-range coordinates (x = 7, or y >= 5) at the anchor SHALL be treated as out of bounds.
REQ-013 map, ship_idx, error and done SHALL be registered outputs; preview SHALL be combinational from map and the current inputs.

Reset
REQ-014 While reset is low, the block SHALL hold map = 0, ship_idx = 0, error = 0, done = 0, state = PLACE, reject counter = 0 and synchronizer flops = 1 (released button).
REQ-015 Reset asserted mid-REJECT or mid-press SHALL abort the operation; after release, no commit SHALL occur until a new falling edge of place_n.

Structure
REQ-016 A shared package battleship_pkg SHALL hold MAP_W = 35, COLS = 5, ROWS = 7, the ship-length table, REJECT_CYCLES and the FSM state enum.
REQ-017 A combinational sub-module ship_mask_gen SHALL map (x, y, orient, length) to a 35-bit mask plus an in_bounds flag. The same sub-module SHALL serve both validation and preview.

Verification
REQ-018 Place ship 0 with x = 0, y = 0, orient = 0 and press -> at N+2, map = 0x0_7000_0000 and ship_idx = 1.
REQ-019 Ship 1 with x = 6, y = 4, orient = 1 and press -> error high for exactly 8 cycles, map unchanged. Then x = 6, y = 3, orient = 1 and press -> map |= 0x2040, ship_idx = 2.
REQ-020 Ship 2 with x = 1, y = 0 (overlap) -> reject. Then x = 3, y = 2 -> map = 0x0_7002_2040, ship_idx = 3, done = 1. A further press -> no change.
REQ-021 Press during REJECT -> ignored; error still drops 8 cycles after the original rejection.
REQ-022 clear asserted in the same cycle as a valid press, and separately during REJECT -> next edge shows map = 0, ship_idx = 0, error = 0.
REQ-023 Reset asserted low while place_n is held low -> no commit after release until place_n goes high and then low again.
